// File: rtl/sargantana_icache_pkg.sv
// Shared types and default sizes for the Sargantana instruction-cache tag path.
package sargantana_icache_pkg;

   localparam int ITAG_N_WAY = 4;
   localparam int ITAG_DEPTH = 64;
   localparam int ITAG_TAG_W = 20;

   // Per-way field as laid out in the tag SRAM word, MSB first.
   typedef struct packed {
      logic                  parity;
      logic                  valid;
      logic [ITAG_TAG_W-1:0] tag;
   } itag_field_t;

   typedef enum logic [1:0] {
      ITAG_IDLE,
      ITAG_INIT,
      ITAG_FLUSH
   } itag_state_e;

endpackage

// File: rtl/sargantana_sram_1rw_bm.sv
// Generic single-port SRAM with a per-bit write mask and a one-cycle registered read.
// The read register holds its value on any cycle that is not a read.
module sargantana_sram_1rw_bm #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 88
) (
   input  logic                     clk_i,
   input  logic                     ce_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [WIDTH-1:0]         wmask_i,
   output logic [WIDTH-1:0]         rdata_o
);

`ifdef SARGANTANA_SRAM_MACRO
   sargantana_sram_macro_1rw_bm #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_macro (
      .clk_i   (clk_i),
      .ce_i    (ce_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .wmask_i (wmask_i),
      .rdata_o (rdata_o)
   );
`else
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk_i) begin
      if (ce_i) begin
         if (we_i) begin
            r_mem[addr_i] <= (r_mem[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
         end else begin
            r_q <= r_mem[addr_i];
         end
      end
   end

   assign rdata_o = r_q;
`endif

endmodule

// File: rtl/sargantana_itag_array.sv
// I-cache tag array: N-way tag store in one masked 1RW SRAM, with registered-read tag compare,
// per-way parity checking and a walking init/flush engine that clears every set.
module sargantana_itag_array
   import sargantana_icache_pkg::*;
#(
   parameter int N_WAY = ITAG_N_WAY,
   parameter int DEPTH = ITAG_DEPTH,
   parameter int TAG_W = ITAG_TAG_W
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [N_WAY-1:0]         req_i,
   input  logic                     we_i,
   input  logic                     vbit_i,
   input  logic                     flush_i,
   input  logic [TAG_W-1:0]         data_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic [TAG_W-1:0]         cmp_tag_i,
   output logic                     ready_o,
   output logic [N_WAY*TAG_W-1:0]   tag_way_o,
   output logic [N_WAY-1:0]         vbit_o,
   output logic [N_WAY-1:0]         hit_o,
   output logic [N_WAY-1:0]         perr_o,
   output logic                     rdata_vld_o
);

   localparam int SET_W  = $clog2(DEPTH);
   localparam int WORD_W = TAG_W + 2;
   localparam int MEM_W  = N_WAY * WORD_W;

   itag_state_e      r_state;
   itag_state_e      w_state_next;
   logic [SET_W-1:0] r_ptr;
   logic [SET_W-1:0] w_ptr_next;

   logic             r_rd_vld;
   logic             r_have_data;
   logic [TAG_W-1:0] r_cmp_tag;

   logic             w_walk;
   logic             w_access;
   logic             w_rd;
   logic [WORD_W-1:0] w_wfield;
   logic             w_sram_ce;
   logic             w_sram_we;
   logic [SET_W-1:0] w_sram_addr;
   logic [MEM_W-1:0] w_sram_wdata;
   logic [MEM_W-1:0] w_sram_wmask;
   logic [MEM_W-1:0] w_sram_rdata;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ITAG_INIT;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_next;
         r_ptr   <= w_ptr_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ptr_next   = r_ptr;
      case (r_state)
         ITAG_IDLE: begin
            if (flush_i) begin
               w_state_next = ITAG_FLUSH;
               w_ptr_next   = '0;
            end
         end
         ITAG_INIT, ITAG_FLUSH: begin
            w_ptr_next = r_ptr + 1'b1;
            if (r_ptr == SET_W'(DEPTH - 1)) begin
               w_state_next = ITAG_IDLE;
            end
         end
         default: begin
            w_state_next = ITAG_INIT;
            w_ptr_next   = '0;
         end
      endcase
   end

   assign ready_o  = (r_state == ITAG_IDLE);
   assign w_walk   = (r_state == ITAG_INIT) || (r_state == ITAG_FLUSH);
   // A flush request in the same cycle as an access takes priority and drops the access.
   assign w_access = ready_o && (|req_i) && !flush_i;
   assign w_rd     = w_access && !we_i;

   assign w_wfield    = {^{vbit_i, data_i}, vbit_i, data_i};
   assign w_sram_ce   = w_walk || w_access;
   assign w_sram_we   = w_walk || (w_access && we_i);
   assign w_sram_addr = w_walk ? r_ptr : addr_i;

   // The walk writes an all-zero word, which is self-consistent: valid=0 and parity=0.
   for (genvar gi = 0; gi < N_WAY; gi++) begin : g_wr
      assign w_sram_wdata[gi*WORD_W +: WORD_W] = w_walk ? '0 : w_wfield;
      assign w_sram_wmask[gi*WORD_W +: WORD_W] = w_walk ? '1 : {WORD_W{req_i[gi]}};
   end

   sargantana_sram_1rw_bm #(
      .DEPTH (DEPTH),
      .WIDTH (MEM_W)
   ) u_sram (
      .clk_i   (clk_i),
      .ce_i    (w_sram_ce),
      .we_i    (w_sram_we),
      .addr_i  (w_sram_addr),
      .wdata_i (w_sram_wdata),
      .wmask_i (w_sram_wmask),
      .rdata_o (w_sram_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rd_vld    <= 1'b0;
         r_have_data <= 1'b0;
         r_cmp_tag   <= '0;
      end else begin
         r_rd_vld <= w_rd;
         if (w_rd) begin
            r_have_data <= 1'b1;
            r_cmp_tag   <= cmp_tag_i;
         end
      end
   end

   assign rdata_vld_o = r_rd_vld;

   // SRAM contents are unknown until the first read completes, so outputs are gated until then.
   for (genvar gi = 0; gi < N_WAY; gi++) begin : g_rd
      logic [TAG_W-1:0] w_tag;
      logic             w_valid;
      logic             w_parity;
      logic             w_perr;

      assign w_tag    = w_sram_rdata[gi*WORD_W +: TAG_W];
      assign w_valid  = w_sram_rdata[gi*WORD_W + TAG_W];
      assign w_parity = w_sram_rdata[gi*WORD_W + TAG_W + 1];
      assign w_perr   = w_valid && (w_parity != (^{w_valid, w_tag}));

      assign tag_way_o[gi*TAG_W +: TAG_W] = r_have_data ? w_tag : '0;
      assign vbit_o[gi] = r_have_data && w_valid;
      assign perr_o[gi] = r_have_data && w_perr;
      assign hit_o[gi]  = r_have_data && w_valid && !w_perr && (w_tag == r_cmp_tag);
   end

endmodule

// File: tb/tb_sargantana_itag_array.sv
// Randomised self-checking bench for sargantana_itag_array against a set/way array model.
module tb_sargantana_itag_array;

   localparam int NW = 4;
   localparam int DP = 64;
   localparam int TW = 20;
   localparam int SW = 6;
   localparam int WW = TW + 2;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [NW-1:0] req_i;
   logic          we_i;
   logic          vbit_i;
   logic          flush_i;
   logic [TW-1:0] data_i;
   logic [SW-1:0] addr_i;
   logic [TW-1:0] cmp_tag_i;
   logic          ready_o;
   logic [NW*TW-1:0] tag_way_o;
   logic [NW-1:0] vbit_o;
   logic [NW-1:0] hit_o;
   logic [NW-1:0] perr_o;
   logic          rdata_vld_o;

   always #5 clk_i = ~clk_i;

   sargantana_itag_array dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req_i),
      .we_i        (we_i),
      .vbit_i      (vbit_i),
      .flush_i     (flush_i),
      .data_i      (data_i),
      .addr_i      (addr_i),
      .cmp_tag_i   (cmp_tag_i),
      .ready_o     (ready_o),
      .tag_way_o   (tag_way_o),
      .vbit_o      (vbit_o),
      .hit_o       (hit_o),
      .perr_o      (perr_o),
      .rdata_vld_o (rdata_vld_o)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference contents: what each way of each set holds, including its stored parity bit.
   logic [TW-1:0] m_tag [DP][NW];
   logic          m_v   [DP][NW];
   logic          m_p   [DP][NW];

   logic [NW*TW-1:0] e_tag;
   logic [NW-1:0]    e_v;
   logic [NW-1:0]    e_hit;
   logic [NW-1:0]    e_perr;
   logic             e_vld;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int s = 0; s < DP; s++) begin
         for (int w = 0; w < NW; w++) begin
            m_tag[s][w] = '0;
            m_v[s][w]   = 1'b0;
            m_p[s][w]   = 1'b0;
         end
      end
   endtask

   task automatic outs_clear();
      e_tag  = '0;
      e_v    = '0;
      e_hit  = '0;
      e_perr = '0;
      e_vld  = 1'b0;
   endtask

   task automatic check_outs(input string tag, input logic exp_ready);
      chk({tag, ".ready"}, 128'(ready_o), 128'(exp_ready));
      chk({tag, ".rvld"},  128'(rdata_vld_o), 128'(e_vld));
      chk({tag, ".tag"},   128'(tag_way_o), 128'(e_tag));
      chk({tag, ".vbit"},  128'(vbit_o), 128'(e_v));
      chk({tag, ".hit"},   128'(hit_o), 128'(e_hit));
      chk({tag, ".perr"},  128'(perr_o), 128'(e_perr));
   endtask

   task automatic idle_inputs();
      req_i     = '0;
      we_i      = 1'b0;
      vbit_i    = 1'b0;
      flush_i   = 1'b0;
      data_i    = '0;
      addr_i    = '0;
      cmp_tag_i = '0;
   endtask

   // One clock of traffic while ready; outputs are checked #1 after the edge that consumed it.
   task automatic cycle(input logic [NW-1:0] req, input logic we, input logic v,
                        input logic [TW-1:0] data, input logic [SW-1:0] addr,
                        input logic [TW-1:0] cmp, input logic flush, input string tag);
      logic pe;
      req_i = req; we_i = we; vbit_i = v; data_i = data;
      addr_i = addr; cmp_tag_i = cmp; flush_i = flush;
      @(posedge clk_i);
      #1;
      idle_inputs();
      e_vld = 1'b0;
      if (flush) begin
         model_clear();
      end else if (req != '0) begin
         if (we) begin
            for (int w = 0; w < NW; w++) begin
               if (req[w]) begin
                  m_tag[addr][w] = data;
                  m_v[addr][w]   = v;
                  m_p[addr][w]   = ^{v, data};
               end
            end
         end else begin
            e_vld = 1'b1;
            for (int w = 0; w < NW; w++) begin
               pe = m_v[addr][w] && (m_p[addr][w] != (^{m_v[addr][w], m_tag[addr][w]}));
               e_tag[w*TW +: TW] = m_tag[addr][w];
               e_v[w]    = m_v[addr][w];
               e_perr[w] = pe;
               e_hit[w]  = m_v[addr][w] && !pe && (m_tag[addr][w] == cmp);
            end
         end
      end
      check_outs(tag, !flush);
      $display("%s req=%b we=%b fl=%b set=%0d rvld=%b vbit=%b hit=%b perr=%b",
               tag, req, we, flush, addr, rdata_vld_o, vbit_o, hit_o, perr_o);
   endtask

   // Counts busy cycles of an init/flush walk while throwing ignored traffic at the array.
   task automatic wait_walk(input string tag);
      int busy;
      busy = 0;
      while (!ready_o && busy < 200) begin
         busy++;
         check_outs({tag, ".busy"}, 1'b0);
         req_i   = NW'($urandom);
         we_i    = 1'(($urandom % 3) != 0);
         vbit_i  = 1'b1;
         flush_i = 1'($urandom);
         data_i  = TW'($urandom);
         addr_i  = SW'($urandom);
         @(posedge clk_i);
         #1;
      end
      idle_inputs();
      chk({tag, ".busy_cycles"}, 128'(busy), 128'(DP));
      $display("%s walk busy=%0d", tag, busy);
   endtask

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [TW-1:0] t;
      logic [TW-1:0] c;
      logic [SW-1:0] a;
      int w;

      idle_inputs();
      rst_i = 1'b1;
      model_clear();
      outs_clear();
      repeat (3) @(posedge clk_i);
      #1;
      check_outs("reset", 1'b0);
      rst_i = 1'b0;
      wait_walk("init");
      check_outs("init_done", 1'b1);

      cycle(4'b0000, 0, 0, '0, 6'd0, '0, 0, "idle");
      cycle(4'b1111, 0, 0, '0, 6'd5, 20'h0, 0, "rd_set5");
      chk("rd_set5.vbit_const", 128'(vbit_o), 128'(4'b0000));

      cycle(4'b0100, 1, 1, 20'hABCDE, 6'd9, '0, 0, "wr_set9");
      cycle(4'b1111, 0, 0, '0, 6'd9, 20'hABCDE, 0, "rd_set9");
      chk("rd_set9.hit_const", 128'(hit_o), 128'(4'b0100));
      chk("rd_set9.tag2_const", 128'(tag_way_o[2*TW +: TW]), 128'(20'hABCDE));

      cycle(4'b0001, 1, 1, 20'h54321, 6'd3, '0, 0, "wr_set3");
      cycle(4'b1111, 0, 0, '0, 6'd3, 20'h12345, 0, "rd_set3_miss");
      chk("rd_set3.vbit0", 128'(vbit_o[0]), 128'(1'b1));
      chk("rd_set3.hit_const", 128'(hit_o), 128'(4'b0000));
      cycle(4'b0000, 0, 0, '0, 6'd0, '0, 0, "hold");

      cycle(4'b0010, 1, 1, 20'h0F0F0, 6'd7, '0, 0, "wr_set7");
      dut.u_sram.r_mem[7][1*WW + 3] = ~dut.u_sram.r_mem[7][1*WW + 3];
      m_tag[7][1][3] = ~m_tag[7][1][3];
      cycle(4'b1111, 0, 0, '0, 6'd7, 20'h0F0F8, 0, "rd_set7_perr");
      chk("rd_set7.perr_const", 128'(perr_o), 128'(4'b0010));

      for (int i = 0; i < 400; i++) begin
         a = SW'($urandom_range(0, 7));
         w = int'($urandom_range(0, NW - 1));
         c = ($urandom % 2 == 1) ? m_tag[a][w] : TW'($urandom);
         t = TW'($urandom);
         cycle(($urandom % 4 == 0) ? 4'b0000 : NW'($urandom), 1'($urandom), 1'($urandom),
               t, a, c, 0, "rand");
      end

      for (int s = 0; s < DP; s++) begin
         cycle(4'b1111, 1, 1, TW'($urandom), SW'(s), '0, 0, "fill");
      end
      cycle(4'b0001, 0, 0, '0, 6'd12, m_tag[12][0], 0, "rd_filled");
      cycle(4'b1111, 1, 1, 20'h11111, 6'd20, '0, 1, "flush");
      wait_walk("flush");
      for (int s = 0; s < DP; s++) begin
         cycle(4'b1111, 0, 0, '0, SW'(s), '0, 0, "rd_flushed");
         chk("rd_flushed.vbit_const", 128'(vbit_o), 128'(4'b0000));
      end

      for (int s = 28; s < 44; s++) begin
         cycle(4'b1111, 1, 1, TW'($urandom | 1), SW'(s), '0, 0, "fill2");
      end
      cycle(4'b1111, 0, 0, '0, 6'd40, m_tag[40][1], 0, "rd_pre_rst");
      cycle(4'b0000, 0, 0, '0, 6'd0, '0, 1, "flush2");
      for (int k = 0; k < 30; k++) begin
         @(posedge clk_i);
         #1;
         check_outs("flush2.busy", 1'b0);
      end
      #2;
      rst_i = 1'b1;
      #1;
      model_clear();
      outs_clear();
      check_outs("rst_mid_walk", 1'b0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      wait_walk("reinit");
      cycle(4'b1111, 0, 0, '0, 6'd40, '0, 0, "rd_after_reinit");
      chk("rd_after_reinit.vbit_const", 128'(vbit_o), 128'(4'b0000));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
